// File: rtl/reg_spill_ctrl.sv
// Register spill/fill sequencer: borrows the register file's read-A and write
// ports to copy masked registers to data memory or back, stalling the core.
module reg_spill_ctrl #(
    parameter int unsigned pw = 2,
    parameter int unsigned MW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic [MW-1:0]   base_addr,
    input  logic [(1<<pw)-1:0] reg_mask,
    output logic            busy,
    output logic            done,
    input  logic [pw:0]     core_rd_addrA,
    input  logic [pw:0]     core_wr_addr,
    input  logic            core_wr_en,
    input  logic [7:0]      core_dat_in,
    output logic [pw:0]     rf_rd_addrA,
    output logic [pw:0]     rf_wr_addr,
    output logic            rf_wr_en,
    output logic [7:0]      rf_dat_in,
    input  logic [7:0]      rf_datA,
    output logic [MW-1:0]   mem_addr,
    output logic            mem_wr_en,
    output logic [7:0]      mem_dat_out,
    input  logic [7:0]      mem_dat_in
);

    localparam int unsigned NR = 1 << pw;

    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [MW-1:0]   base_q, base_d;
    logic [NR-1:0]   mask_q, mask_d;
    logic [pw-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [pw-1:0]   first_idx;
    logic [pw-1:0]   next_idx;
    logic            has_next;
    logic            active;
    logic            do_spill;
    logic            do_fill;
    logic [pw:0]     idx_ext;

    // Lowest set bit of the incoming mask, and next set bit above the current index.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (reg_mask[j] && (first_idx == '0) && !reg_mask[0]) begin
                first_idx = pw'(j);
            end
            if (mask_q[j] && (j > 32'(idx_q)) && !has_next) begin
                next_idx = pw'(j);
                has_next = 1'b1;
            end
        end
    end

    // Next-state and latched transfer parameters.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    base_d = base_addr;
                    mask_d = reg_mask;
                    idx_d  = first_idx;
                    if (reg_mask == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mode ? S_FILL : S_SPILL;
                    end
                end
            end
            S_SPILL, S_FILL: begin
                if (has_next) begin
                    idx_d = next_idx;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_SPILL) || (state_d == S_FILL);
        done_d = (state_d == S_DONE);
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            base_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Port steering: core pass-through when idle, controller owns ports while busy.
    // Controller writes are suppressed in a reset cycle so an abort writes nothing more.
    always_comb begin
        active   = (state_q == S_SPILL) || (state_q == S_FILL);
        do_spill = active && !mode_q;
        do_fill  = active && mode_q;
        idx_ext  = {1'b0, idx_q};

        rf_rd_addrA = core_rd_addrA;
        rf_wr_addr  = core_wr_addr;
        rf_wr_en    = core_wr_en;
        rf_dat_in   = core_dat_in;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_dat_out = '0;

        if (active) begin
            rf_rd_addrA = idx_ext;
            rf_wr_en    = 1'b0;
            mem_addr    = base_q + MW'(idx_q);
        end
        if (do_spill) begin
            mem_dat_out = rf_datA;
            mem_wr_en   = !reset;
        end
        if (do_fill) begin
            rf_wr_addr = idx_ext;
            rf_dat_in  = mem_dat_in;
            rf_wr_en   = !reset;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// Bench for reg_spill_ctrl: register file and memory around the DUT, a
// queue-based transfer model, per-cycle output compare and directed scenarios.
module tb_reg_spill_ctrl;

    localparam int PW = 2;
    localparam int MWD = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] base_addr;
    logic [3:0] reg_mask;
    logic       busy;
    logic       done;
    logic [2:0] core_rd_addrA;
    logic [2:0] core_wr_addr;
    logic       core_wr_en;
    logic [7:0] core_dat_in;
    logic [2:0] rf_rd_addrA;
    logic [2:0] rf_wr_addr;
    logic       rf_wr_en;
    logic [7:0] rf_dat_in;
    logic [7:0] rf_datA;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_dat_out;
    logic [7:0] mem_dat_in;

    // backdoor memory setup
    logic       bd_init;
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_dat;

    int total;
    int bad;

    reg_spill_ctrl #(.pw(PW), .MW(MWD)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
        .core_rd_addrA(core_rd_addrA), .core_wr_addr(core_wr_addr),
        .core_wr_en(core_wr_en), .core_dat_in(core_dat_in),
        .rf_rd_addrA(rf_rd_addrA), .rf_wr_addr(rf_wr_addr), .rf_wr_en(rf_wr_en),
        .rf_dat_in(rf_dat_in), .rf_datA(rf_datA), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_dat_out(mem_dat_out), .mem_dat_in(mem_dat_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: register file and data memory actually driven by the DUT
    logic [7:0] env_regs [4];
    logic [7:0] env_mem  [256];

    assign rf_datA    = env_regs[rf_rd_addrA[1:0]];
    assign mem_dat_in = env_mem[mem_addr];

    always @(posedge clk) begin
        if (bd_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i * 7 + 3);
            for (int i = 0; i < 4; i++) env_regs[i] <= 8'h00;
        end else begin
            if (bd_we) env_mem[bd_addr] <= bd_dat;
            if (rf_wr_en) env_regs[rf_wr_addr[1:0]] <= rf_dat_in;
            if (mem_wr_en) env_mem[mem_addr] <= mem_dat_out;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a queue of register indices, one per cycle
    int         m_phase;   // 0 idle, 1 transferring, 2 completion cycle
    int         m_q[$];
    logic       m_mode;
    int         m_base;
    logic [7:0] exp_regs [4];
    logic [7:0] exp_mem  [256];
    bit         started;

    initial begin
        m_phase = 0;
        started = 1'b0;
    end

    always @(posedge clk) begin
        started = 1'b1;
        if (bd_init) begin
            for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
            for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
        end else begin
            if (bd_we) exp_mem[bd_addr] = bd_dat;
            if (m_phase == 1) begin
                if (!reset) begin
                    int i;
                    int a;
                    i = m_q[0];
                    a = (m_base + i) % 256;
                    if (!m_mode) exp_mem[a] = exp_regs[i];
                    else         exp_regs[i] = exp_mem[a];
                end
            end else if (core_wr_en) begin
                exp_regs[core_wr_addr[1:0]] = core_dat_in;
            end
        end
        if (reset) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_mode = mode;
                    m_base = int'(base_addr);
                    m_q.delete();
                    for (int i = 0; i < 4; i++) if (reg_mask[i]) m_q.push_back(i);
                    m_phase = (m_q.size() == 0) ? 2 : 1;
                end
                1: begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare of DUT outputs against the model
    int done_seen;
    initial done_seen = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            if (done) done_seen++;
            if (m_phase == 1) begin
                int i;
                int a;
                i = m_q[0];
                a = (m_base + i) % 256;
                if (reset) begin
                    chk("mem_wr_en_rst", 32'(mem_wr_en), 0);
                    chk("rf_wr_en_rst", 32'(rf_wr_en), 0);
                end else if (!m_mode) begin
                    chk("spill_mem_wr_en", 32'(mem_wr_en), 1);
                    chk("spill_rf_wr_en", 32'(rf_wr_en), 0);
                    chk("spill_mem_addr", 32'(mem_addr), 32'(a));
                    chk("spill_rd_addr", 32'(rf_rd_addrA), 32'(i));
                    chk("spill_data", 32'(mem_dat_out), 32'(exp_regs[i]));
                end else begin
                    chk("fill_mem_wr_en", 32'(mem_wr_en), 0);
                    chk("fill_rf_wr_en", 32'(rf_wr_en), 1);
                    chk("fill_mem_addr", 32'(mem_addr), 32'(a));
                    chk("fill_wr_addr", 32'(rf_wr_addr), 32'(i));
                    chk("fill_data", 32'(rf_dat_in), 32'(exp_mem[a]));
                end
            end else begin
                chk("idle_mem_wr_en", 32'(mem_wr_en), 0);
                chk("idle_mem_addr", 32'(mem_addr), 0);
                chk("pass_wr_en", 32'(rf_wr_en), 32'(core_wr_en));
                chk("pass_wr_addr", 32'(rf_wr_addr), 32'(core_wr_addr));
                chk("pass_dat", 32'(rf_dat_in), 32'(core_dat_in));
                chk("pass_rd_addr", 32'(rf_rd_addrA), 32'(core_rd_addrA));
            end
        end
    end

    task automatic check_arrays(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(env_regs[i]), 32'(exp_regs[i]));
        for (int i = 0; i < 256; i++)
            chk($sformatf("%s_mem%0h", tag, i), 32'(env_mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic core_wr(input logic [1:0] a, input logic [7:0] d);
        core_wr_en   = 1'b1;
        core_wr_addr = {1'b0, a};
        core_dat_in  = d;
        @(posedge clk); #1;
        core_wr_en   = 1'b0;
    endtask

    task automatic bd_mem(input logic [7:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_dat  = d;
        @(posedge clk); #1;
        bd_we   = 1'b0;
    endtask

    // Launch a transfer and measure busy length and done latency over a bounded window
    task automatic xfer(input logic m, input logic [7:0] b, input logic [3:0] msk, input int exp_n);
        int busy_cnt;
        int done_at;
        int done_cnt;
        busy_cnt = 0;
        done_at  = 0;
        done_cnt = 0;
        start = 1'b1; mode = m; base_addr = b; reg_mask = msk;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_n));
        chk("done_latency", 32'(done_at), 32'(exp_n + 1));
        chk("done_count", 32'(done_cnt), 1);
    endtask

    initial begin
        int d0;
        total = 0; bad = 0;
        reset = 1'b1; bd_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        start = 1'b0; mode = 1'b0; base_addr = '0; reg_mask = '0;
        core_rd_addrA = '0; core_wr_addr = '0; core_wr_en = 1'b0; core_dat_in = '0;
        @(posedge clk); #1;
        bd_init = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_mem_wr_en", 32'(mem_wr_en), 0);

        // preload registers through the core pass-through path, then spill
        core_wr(2'd0, 8'h11); core_wr(2'd1, 8'h22); core_wr(2'd2, 8'h33); core_wr(2'd3, 8'h44);
        xfer(1'b0, 8'h10, 4'b1111, 4);
        chk("spill_m10", 32'(env_mem[8'h10]), 32'h11);
        chk("spill_m11", 32'(env_mem[8'h11]), 32'h22);
        chk("spill_m12", 32'(env_mem[8'h12]), 32'h33);
        chk("spill_m13", 32'(env_mem[8'h13]), 32'h44);
        check_arrays("spill");

        // sparse fill
        bd_mem(8'h21, 8'hA5); bd_mem(8'h23, 8'h5A);
        xfer(1'b1, 8'h20, 4'b1010, 2);
        chk("fill_r0", 32'(env_regs[0]), 32'h11);
        chk("fill_r1", 32'(env_regs[1]), 32'hA5);
        chk("fill_r2", 32'(env_regs[2]), 32'h33);
        chk("fill_r3", 32'(env_regs[3]), 32'h5A);
        check_arrays("fill");

        // address wrap
        xfer(1'b0, 8'hFE, 4'b1111, 4);
        chk("wrap_mFE", 32'(env_mem[8'hFE]), 32'h11);
        chk("wrap_mFF", 32'(env_mem[8'hFF]), 32'hA5);
        chk("wrap_m00", 32'(env_mem[8'h00]), 32'h33);
        chk("wrap_m01", 32'(env_mem[8'h01]), 32'h5A);

        // empty mask
        xfer(1'b0, 8'h80, 4'b0000, 0);
        chk("empty_m80", 32'(env_mem[8'h80]), 32'h83);
        check_arrays("empty");

        // fill while the core tries to write and re-start
        bd_mem(8'h20, 8'h3C); bd_mem(8'h21, 8'h4D); bd_mem(8'h22, 8'h5E); bd_mem(8'h23, 8'h6F);
        d0 = done_seen;
        start = 1'b1; mode = 1'b1; base_addr = 8'h20; reg_mask = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        core_wr_en = 1'b1; core_wr_addr = 3'd0; core_dat_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base_addr = 8'h90; reg_mask = 4'b0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        core_wr_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("interf_done_pulses", 32'(done_seen - d0), 1);
        chk("interf_r0", 32'(env_regs[0]), 32'h3C);
        chk("interf_r1", 32'(env_regs[1]), 32'h4D);
        chk("interf_r2", 32'(env_regs[2]), 32'h5E);
        chk("interf_r3", 32'(env_regs[3]), 32'h6F);
        chk("interf_m90", 32'(env_mem[8'h90]), 32'(8'(8'h90 * 7 + 3)));
        check_arrays("interf");

        // reset in the middle of a 4-register spill
        bd_mem(8'h40, 8'h00); bd_mem(8'h41, 8'h00); bd_mem(8'h42, 8'h00); bd_mem(8'h43, 8'h00);
        d0 = done_seen;
        start = 1'b1; mode = 1'b0; base_addr = 8'h40; reg_mask = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_seen - d0), 0);
        chk("abort_m40", 32'(env_mem[8'h40]), 32'h3C);
        chk("abort_m41", 32'(env_mem[8'h41]), 32'h4D);
        chk("abort_m42", 32'(env_mem[8'h42]), 32'h00);
        chk("abort_m43", 32'(env_mem[8'h43]), 32'h00);
        core_wr(2'd2, 8'h99);
        chk("abort_core_wr", 32'(env_regs[2]), 32'h99);
        check_arrays("abort");

        // random traffic
        for (int n = 0; n < 800; n++) begin
            start         = ($urandom_range(0, 3) == 0);
            mode          = 1'($urandom);
            base_addr     = 8'($urandom);
            reg_mask      = 4'($urandom);
            core_wr_en    = 1'($urandom);
            core_wr_addr  = {1'b0, 2'($urandom)};
            core_rd_addrA = {1'b0, 2'($urandom)};
            core_dat_in   = 8'($urandom);
            reset         = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0; core_wr_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_arrays("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_spill_ctrl.md
Name: reg_spill_ctrl

Overview:
- Sequencer that takes over the register file's read-A and write ports to spill registers to data memory or fill them from data memory.
- Used for context save/restore around calls and interrupts.
- Sits between the core's register-file port drivers and the register file, multiplexing them, and drives the data-memory port while active.
- Stalls the core for the duration of a transfer.

Parameters:
- pw, 2, register pointer parameter: 2**pw registers, register address width pw+1 (top bit driven 0).
- MW, 8, data-memory address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- mode  input  1  0 = spill (reg->mem), 1 = fill (mem->reg); latched with start.
- base_addr  input  MW  memory base address; latched with start.
- reg_mask  input  2**pw  bit i set = transfer register i; latched with start.
- busy  output  1  transfer in progress (SPILL/FILL states).
- done  output  1  one-cycle completion pulse.
- core_rd_addrA  input  pw+1  core read-A address.
- core_wr_addr  input  pw+1  core write address.
- core_wr_en  input  1  core write enable.
- core_dat_in  input  8  core write data.
- rf_rd_addrA  output  pw+1  to register file read-A address.
- rf_wr_addr  output  pw+1  to register file write address.
- rf_wr_en  output  1  to register file write enable.
- rf_dat_in  output  8  to register file write data.
- rf_datA  input  8  register file read-A data (combinational read).
- mem_addr  output  MW  data-memory address.
- mem_wr_en  output  1  data-memory write enable.
- mem_dat_out  output  8  data-memory write data.
- mem_dat_in  input  8  data-memory read data (combinational read).

Behaviour:
- States: IDLE, SPILL, FILL, DONE. Reset forces IDLE, clears latched mode/base/mask and index; busy=0, done=0, mem_wr_en=0.
- IDLE: rf_* = core_* pass-through, mem_wr_en=0, mem_addr=0.
  - On start at edge T: latch mode, base_addr, reg_mask; index = lowest set mask bit.
  - If latched mask==0: go DONE. Otherwise go SPILL (mode 0) or FILL (mode 1).
- SPILL, one register per cycle at current index i:
  - rf_rd_addrA=i, mem_addr=base+i (mod 2**MW), mem_dat_out=rf_datA, mem_wr_en=1, rf_wr_en=0.
- FILL, one register per cycle at current index i:
  - mem_addr=base+i (mod 2**MW), rf_wr_addr=i, rf_dat_in=mem_dat_in, rf_wr_en=1, mem_wr_en=0.
- Index advance:
  - Next index = next higher set mask bit.
  - Clear bits consume no cycle; the memory layout stays sparse (slot i always at base+i).
  - After the highest set bit, go DONE.
- DONE: done=1 for exactly one cycle, busy=0, ports pass-through, then IDLE. start is ignored in DONE.
- Latency: with N set mask bits, busy is high for N cycles (T+1..T+N) and done is high at T+N+1. With mask==0, done is high at T+1.
- While busy:
  - core_wr_en is blocked (rf_wr_en driven only by the controller).
  - core_rd_addrA is ignored.
  - start is ignored; a new start is accepted only in IDLE.
- Address wrap: base+i wraps modulo 2**MW (e.g. base 0xFE, i=3 -> 0x01).
- Reset mid-transfer: IDLE on the next edge with no further memory or register writes. Transfers already completed stand; done is not pulsed.
- rf_rd_addrA, rf_wr_addr and mem_addr upper bits are zero-extended from the index.

Test Plan:
- Preload regs {0x11,0x22,0x33,0x44}; spill, base=0x10, mask=4'b1111 -> mem[0x10..0x13]=11,22,33,44; busy high exactly 4 cycles; done at T+5.
- Fill, base=0x20, mask=4'b1010, mem[0x21]=0xA5, mem[0x23]=0x5A -> r1=A5, r3=5A, r0/r2 unchanged; busy 2 cycles; done at T+3.
- Spill, base=0xFE, mask=4'b1111 -> writes land at 0xFE,0xFF,0x00,0x01.
- start with mask=0 -> no memory/register writes; done pulses at T+1; busy never asserts.
- During a fill, hold core_wr_en=1, core_wr_addr=0, core_dat_in=0xFF, and pulse start again -> r0 gets only the memory value; the second start is ignored; exactly one done pulse.
- Assert reset after 2 cycles of a 4-register spill -> only mem[base], mem[base+1] written; busy=0 next cycle; no done; core writes pass through afterwards.
